// File: rtl/lca_seq_pkg.sv
// Shared definitions for the sequential lookahead adder.
// Holds the FSM state encoding and the elaboration-time helpers that
// derive the slice count and counter width from the top-level widths.
// Optional feature macro used by the sequencer: LCA_SEQ_OVF_EN.
package lca_seq_pkg;

  // 2-bit state encoding of the sequencer FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) returns 0
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Number of slice passes needed for one addition, never below one
  function automatic int calc_num_slices(input int total_w, input int slice_w);
    int n;
    n = total_w / slice_w;
    return (n < 1) ? 1 : n;
  endfunction

  // Slice counter width, never below one bit
  function automatic int calc_cnt_w(input int num_slices);
    int w;
    w = clog2(num_slices);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lca_seq_adder_cla_slice.sv
// Combinational carry-lookahead slice shared by the sequencer.
// Per-bit propagate/generate feed the carry chain; the carry into bit j
// is g[j-1] | (c[j-1] & p[j-1]) with c[0] the slice carry-in.
module cla_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Carry chain built from propagate/generate terms
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int j = 1; j <= SLICE_W; j++) begin
      c[j] = g[j-1] | (c[j-1] & p[j-1]);
    end
  end

  assign s  = p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];

endmodule

// File: rtl/lca_seq_adder.sv
// Multi-cycle wide adder: one SLICE_W-bit lookahead slice is reused for
// NUM_SLICES cycles, LSB slice first, with the inter-slice carry held in
// a register. Operands enter on the in_valid/in_ready handshake and the
// result leaves on the out_valid/out_ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high; valid never depends on ready.
// Here in_ready is high only in IDLE and out_valid only in DONE, so at
// most one operation is ever in flight.
//
// Optional feature: define LCA_SEQ_OVF_EN to add ovf_out, the signed
// two's-complement overflow flag of the finished sum.
module lca_seq_adder
  import lca_seq_pkg::*;
#(
  parameter int TOTAL_W = 16,
  parameter int SLICE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] a_in,
  input  logic [TOTAL_W-1:0] b_in,
  input  logic               c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] sum_out,
  output logic               co_out
`ifdef LCA_SEQ_OVF_EN
  ,
  output logic               ovf_out
`endif
);

  localparam int NUM_SLICES = calc_num_slices(TOTAL_W, SLICE_W);
  localparam int CNT_W      = calc_cnt_w(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  // FSM state and datapath registers
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [TOTAL_W-1:0] a_q;
  logic [TOTAL_W-1:0] b_q;
  logic [TOTAL_W-1:0] sum_q;

`ifdef LCA_SEQ_OVF_EN
  // Operand sign bits, kept because the shift registers lose them
  logic               a_msb_q;
  logic               b_msb_q;
`endif

  // Shared slice signals
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic [TOTAL_W-1:0] sum_next;

  cla_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a  (a_q[SLICE_W-1:0]),
    .b  (b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Each slice result enters at the MSB end, so after NUM_SLICES passes
  // the first (least significant) slice has reached the bottom.
  generate
    if (NUM_SLICES > 1) begin : g_shift_sum
      assign sum_next = {slice_s, sum_q[TOTAL_W-1:SLICE_W]};
    end else begin : g_single_sum
      assign sum_next = slice_s;
    end
  endgenerate

  // Sequencer FSM with operand/sum shift registers and carry register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef LCA_SEQ_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt_q   <= '0;
`ifdef LCA_SEQ_OVF_EN
            a_msb_q <= a_in[TOTAL_W-1];
            b_msb_q <= b_in[TOTAL_W-1];
`endif
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_next;
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          carry_q <= slice_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // in_valid is deliberately ignored until the result is taken
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode the state; both drop while reset is held
  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = (state_q == ST_DONE) & ~rst;

  // After the last slice the carry register holds the final carry-out
  assign sum_out = sum_q;
  assign co_out  = carry_q;

`ifdef LCA_SEQ_OVF_EN
  // Overflow: like-signed operands producing an opposite-signed sum
  assign ovf_out = (a_msb_q == b_msb_q) & (sum_q[TOTAL_W-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_lca_seq_adder.sv
// Directed bench for lca_seq_adder (TOTAL_W=16, SLICE_W=4).
// Table of hand-computed vectors plus hand-written sequences for
// backpressure, reset mid-operation and back-to-back issue.
module tb_lca_seq_adder;

  localparam int W = 16;
  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         co_out;
`ifdef LCA_SEQ_OVF_EN
  logic         ovf_out;
`endif

  int errors;
  int checks;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  logic [W:0] exp_q[$];

  lca_seq_adder #(
    .TOTAL_W (16),
    .SLICE_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .co_out    (co_out)
`ifdef LCA_SEQ_OVF_EN
    ,
    .ovf_out   (ovf_out)
`endif
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (at negedges) until in_ready, bounded
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Wait for out_valid after the accepting edge; returns edges elapsed
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction: accept, check latency and result, drain
  task automatic run_op(input string name, input vec_t v);
    int lat;
    @(negedge clk);
    wait_ready(name);
    a_in = v.a;
    b_in = v.b;
    c_in = v.ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = $urandom_range(0, 65535);
    b_in = $urandom_range(0, 65535);
    c_in = 1'b0;
    wait_result(lat);
    check({name, "_latency"}, lat, LAT);
    check({name, "_sum"}, sum_out, v.sum);
    check({name, "_co"}, co_out, v.co);
`ifdef LCA_SEQ_OVF_EN
    check({name, "_ovf"}, ovf_out, v.ovf);
`endif
    check({name, "_in_ready_busy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    int cyc;
    int acc;
    int got;
    int last_acc;
    logic [W:0] exp_v;

    errors = 0;
    checks = 0;

    //           a         b        ci    sum       co    ovf
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[9] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_sum", sum_out, 16'h0000);
    check("rst_co", co_out, 1'b0);
`ifdef LCA_SEQ_OVF_EN
    check("rst_ovf", ovf_out, 1'b0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held 5 cycles while a new op waits
    @(negedge clk);
    wait_ready("bp");
    a_in = 16'h1234;
    b_in = 16'h4321;
    c_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in = 16'h0001;
    b_in = 16'h0001;
    c_in = 1'b0;
    wait_result(lat);
    check("bp_latency", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_valid", i), out_valid, 1'b1);
      check($sformatf("bp_hold%0d_sum", i), sum_out, 16'h5555);
      check($sformatf("bp_hold%0d_co", i), co_out, 1'b0);
      check($sformatf("bp_hold%0d_in_ready", i), in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_valid", out_valid, 1'b0);
    check("bp_idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_pending_latency", lat, LAT);
    check("bp_pending_sum", sum_out, 16'h0002);
    check("bp_pending_co", co_out, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during RUN with counter at 2
    wait_ready("rst_mid");
    a_in = 16'hFFFF;
    b_in = 16'h0000;
    c_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_valid", out_valid, 1'b0);
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("rst_mid_no_result", seen, 0);
    end
    run_op("rst_mid_next", vecs[3]);

    // Back-to-back: in_valid held, out_ready held, four ops
    @(negedge clk);
    out_ready = 1'b1;
    a_in = vecs[4].a;
    b_in = vecs[4].b;
    c_in = vecs[4].ci;
    in_valid = 1'b1;
    cyc = 0;
    acc = 0;
    got = 0;
    last_acc = -1;
    while (got < 4 && cyc < 200) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("b2b_res%0d", got), {co_out, sum_out}, exp_v);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        if (last_acc >= 0) check($sformatf("b2b_spacing%0d", acc), cyc - last_acc, 6);
        last_acc = cyc;
        exp_q.push_back({vecs[4 + acc].co, vecs[4 + acc].sum});
        acc++;
        @(posedge clk);
        #1;
        if (acc < 4) begin
          a_in = vecs[4 + acc].a;
          b_in = vecs[4 + acc].b;
          c_in = vecs[4 + acc].ci;
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("b2b_results_done", got, 4);
    check("b2b_accepts", acc, 4);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lca_seq_adder.md
Name: lca_seq_adder

Overview:
- Multi-cycle wide adder sequencer that time-shares one SLICE_W-bit carry-lookahead slice across a TOTAL_W-bit addition.
- Accepts one operand pair over a valid/ready handshake and processes one slice per clock, LSB slice first, with a registered inter-slice carry.
- Returns the sum and carry-out over a second valid/ready handshake.
- Sits between datapath requesters and the shared lookahead adder slice when a full-width lookahead adder is too costly.

Parameters:
- TOTAL_W, 16, operand/sum width. Must be an integer multiple of SLICE_W.
- SLICE_W, 4, width of the shared lookahead slice processed per cycle.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and carry-in present.
- in_ready  output  1  block can accept operands.
- a_in  input  TOTAL_W  operand A.
- b_in  input  TOTAL_W  operand B.
- c_in  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum_out  output  TOTAL_W  A + B + c_in, modulo 2^TOTAL_W.
- co_out  output  1  carry-out of bit TOTAL_W-1.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
  - While rst is high at a clock edge: state IDLE; slice counter, carry register, operand registers and sum register all cleared.
  - Outputs under reset: out_valid=0, sum_out=0, co_out=0. in_ready=0 while rst is asserted.
- Derived constants: NUM_SLICES = TOTAL_W/SLICE_W (at least 1); CNT_W = clog2(NUM_SLICES), minimum 1.
- States:
  - IDLE: in_ready=1, out_valid=0. If in_valid at the edge:
    - capture a_in and b_in into shift registers, c_in into the carry register;
    - counter=0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - the slice adds the low SLICE_W bits of A and B plus the carry register;
    - the slice sum is shifted into the sum register from the MSB end;
    - A and B shift right by SLICE_W;
    - the carry register takes the slice carry-out;
    - the counter increments.
    - On the edge where counter==NUM_SLICES-1, go to DONE.
  - DONE: out_valid=1, in_ready=0; sum_out and co_out are stable. If out_ready at the edge, go to IDLE. in_valid is ignored in this state.
- Latency and throughput:
  - out_valid rises exactly NUM_SLICES edges after the accepting edge.
  - Minimum issue interval is NUM_SLICES+2 cycles: no overlap, one operation in flight.
- Output validity: sum_out and co_out are defined only while out_valid=1; they may change during RUN.
- Operand stability: operands must be stable only at the accepting edge.
- Carry behaviour: the carry propagates through all slices, so all-ones plus carry-in ripples across every cycle.
- NUM_SLICES==1: RUN lasts exactly one cycle.
- Reset mid-operation (RUN or DONE): the operation is abandoned and no result is produced; in_ready=1 on the first cycle after rst deasserts.
- out_ready while not out_valid: ignored.

Optional Feature:
- Macro: LCA_SEQ_OVF_EN.
- When defined:
  - adds output port ovf_out (1 bit), signed two's-complement overflow;
  - ovf_out = (A[MSB]==B[MSB]) & (sum[MSB]!=A[MSB]), with the operand MSBs captured at the accepting edge;
  - ovf_out is valid with out_valid and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lca_seq_pkg:
  - state encoding IDLE/RUN/DONE as a 2-bit localparam set;
  - NUM_SLICES and CNT_W derivation helpers;
  - clog2 function.
- One sub-module, cla_slice (parameter SLICE_W), the combinational lookahead slice:
  - inputs a, b, ci; outputs s, co;
  - internal per-bit propagate/generate;
  - carry c[j] = g[j-1] | c[j-1]&p[j-1].
- The sequencer holds all registers and the FSM.

Test Plan (TOTAL_W=16, SLICE_W=4):
- Basic add: A=0x1234, B=0x4321, c_in=0 accepted at edge k -> out_valid at edge k+4, sum_out=0x5555, co_out=0.
- Full ripple: A=0xFFFF, B=0x0000, c_in=1 -> sum_out=0x0000, co_out=1. Also A=0xFFFF, B=0xFFFF, c_in=1 -> 0xFFFF, co_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, sum_out and co_out stable, in_ready=0, and a concurrent in_valid (A=0x0001) is not accepted; raise out_ready -> IDLE next edge, then the pending op is accepted.
- Reset mid-op: assert rst for 1 cycle in RUN (counter=2) -> no out_valid, in_ready=1 after release; then A=0x0001, B=0x0001 -> sum_out=0x0002.
- Back-to-back: in_valid held high and out_ready=1 for 4 ops -> acceptances spaced exactly 6 cycles apart, results in order.
- LCA_SEQ_OVF_EN defined: A=0x7FFF, B=0x0001 -> sum_out=0x8000, co_out=0, ovf_out=1; A=0x8000, B=0x8000 -> 0x0000, co_out=1, ovf_out=1; A=0xFFFF, B=0x0001 -> ovf_out=0.
